// File: rtl/regfile_param_pkg.sv
// Shared definitions for the parametrised register file: clear-engine state
// encoding and the default widths used by decode and writeback.
package regfile_param_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_t;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits. A reservation sets a bit, a completed
// write clears it, and a flush clears every bit at once. When a set and a
// clear hit the same register in one cycle, the set wins.
module regfile_scoreboard
  import regfile_param_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_adr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_adr,
  input  logic [ADDR_W-1:0] r_adr,
  input  logic [ADDR_W-1:0] s_adr,
  output logic              pend_r,
  output logic              pend_s
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;

  // Next pend vector: flush dominates, then set overrides clear; bit 0 pinned low for a hardwired-zero register
  always_comb begin
    pend_nxt = pend;
    if (flush) begin
      pend_nxt = '0;
    end else begin
      if (clr_en) pend_nxt[clr_adr] = 1'b0;
      if (set_en) pend_nxt[set_adr] = 1'b1;
    end
    if (ZR) pend_nxt[0] = 1'b0;
  end

  // Pend bit storage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pend <= '0;
    else        pend <= pend_nxt;
  end

  // Pending flags are the registered state only; no same-cycle forwarding
  assign pend_r = pend[r_adr];
  assign pend_s = pend[s_adr];

endmodule

// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with write-to-read bypass,
// a pending-write scoreboard and a sequential bulk-clear engine.
module regfile_param
  import regfile_param_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] r_adr,
  input  logic [ADDR_W-1:0] s_adr,
  input  logic [ADDR_W-1:0] w_adr,
  input  logic [DATA_W-1:0] w,
  input  logic              we,
  output logic              w_ack,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_adr,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [DATA_W-1:0] r_bin,
  output logic [DATA_W-1:0] s_bin,
  output logic              pend_r,
  output logic              pend_s
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  rf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              idle;
  logic              rsv_ok;
  logic              flush;

  assign idle     = (state == ST_IDLE);
  assign clr_busy = (state == ST_CLEAR);
  assign w_ack    = we && idle && !(ZR && (w_adr == '0));
  assign rsv_ok   = rsv_en && idle && !(ZR && (rsv_adr == '0));
  assign flush    = idle && clr_req;

  // Clear-engine state and sweep counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Clear-engine next state: one register zeroed per cycle, DEPTH cycles total
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Storage array: clear sweep has priority; writes only land while idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_busy) begin
      mem[cnt] <= '0;
    end else if (w_ack) begin
      mem[w_adr] <= w;
    end
  end

  // Read ports with per-port bypass of the accepted write; hardwired zero skips bypass
  always_comb begin
    r_bin = mem[r_adr];
    s_bin = mem[s_adr];
    if (w_ack && (w_adr == r_adr)) r_bin = w;
    if (w_ack && (w_adr == s_adr)) s_bin = w;
    if (ZR && (r_adr == '0)) r_bin = '0;
    if (ZR && (s_adr == '0)) s_bin = '0;
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush),
    .set_en (rsv_ok),
    .set_adr(rsv_adr),
    .clr_en (w_ack),
    .clr_adr(w_adr),
    .r_adr  (r_adr),
    .s_adr  (s_adr),
    .pend_r (pend_r),
    .pend_s (pend_s)
  );

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: one default instance and one with a
// hardwired-zero register 0, both driven by the same stimulus.
module tb_regfile_param;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] r_adr = '0, s_adr = '0, w_adr = '0, rsv_adr = '0;
  logic [DATA_W-1:0] w = '0;
  logic              we = 1'b0, rsv_en = 1'b0, clr_req = 1'b0;

  logic              w_ack, clr_busy, pend_r, pend_s;
  logic [DATA_W-1:0] r_bin, s_bin;
  logic              z_w_ack, z_clr_busy, z_pend_r, z_pend_s;
  logic [DATA_W-1:0] z_r_bin, z_s_bin;

  int total = 0;
  int bad   = 0;
  int busy_cnt;

  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0)) dut (
    .clock(clock), .reset(reset), .r_adr(r_adr), .s_adr(s_adr), .w_adr(w_adr),
    .w(w), .we(we), .w_ack(w_ack), .rsv_en(rsv_en), .rsv_adr(rsv_adr),
    .clr_req(clr_req), .clr_busy(clr_busy), .r_bin(r_bin), .s_bin(s_bin),
    .pend_r(pend_r), .pend_s(pend_s)
  );

  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut_z (
    .clock(clock), .reset(reset), .r_adr(r_adr), .s_adr(s_adr), .w_adr(w_adr),
    .w(w), .we(we), .w_ack(z_w_ack), .rsv_en(rsv_en), .rsv_adr(rsv_adr),
    .clr_req(clr_req), .clr_busy(z_clr_busy), .r_bin(z_r_bin), .s_bin(z_s_bin),
    .pend_r(z_pend_r), .pend_s(z_pend_s)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // reset state
    tick(); tick();
    r_adr = 3'd3; s_adr = 3'd6;
    #1;
    chk("rst_r_bin", 32'(r_bin), 32'h0);
    chk("rst_s_bin", 32'(s_bin), 32'h0);
    chk("rst_clr_busy", 32'(clr_busy), 32'h0);
    chk("rst_pend_r", 32'(pend_r), 32'h0);
    reset = 1'b1;
    tick();

    // basic write then read on both ports
    we = 1'b1; w_adr = 3'd3; w = 16'hBEEF;
    tick();
    we = 1'b0; r_adr = 3'd3; s_adr = 3'd3;
    #1;
    chk("rd_r3_r", 32'(r_bin), 32'hBEEF);
    chk("rd_r3_s", 32'(s_bin), 32'hBEEF);

    // bypass on port R only
    we = 1'b1; w_adr = 3'd5; w = 16'h1234; r_adr = 3'd5; s_adr = 3'd3;
    #1;
    chk("byp_w_ack", 32'(w_ack), 32'h1);
    chk("byp_r", 32'(r_bin), 32'h1234);
    chk("byp_s_nobyp", 32'(s_bin), 32'hBEEF);
    tick();
    we = 1'b0;
    #1;
    chk("byp_mem5", 32'(r_bin), 32'h1234);

    // bypass on both ports at once
    we = 1'b1; w_adr = 3'd4; w = 16'h4444; r_adr = 3'd4; s_adr = 3'd4;
    #1;
    chk("byp2_r", 32'(r_bin), 32'h4444);
    chk("byp2_s", 32'(s_bin), 32'h4444);
    tick();
    we = 1'b0;

    // reservation visible next cycle only
    rsv_en = 1'b1; rsv_adr = 3'd2; r_adr = 3'd2;
    #1;
    chk("rsv_same_cyc", 32'(pend_r), 32'h0);
    tick();
    rsv_en = 1'b0;
    #1;
    chk("rsv_pend", 32'(pend_r), 32'h1);
    we = 1'b1; w_adr = 3'd2; w = 16'h0007;
    #1;
    chk("wr_pend_nobyp", 32'(pend_r), 32'h1);
    tick();
    we = 1'b0;
    #1;
    chk("wr_pend_clr", 32'(pend_r), 32'h0);
    chk("wr_r2", 32'(r_bin), 32'h0007);

    // reserve and write the same register together: set wins, data lands
    rsv_en = 1'b1; rsv_adr = 3'd6; we = 1'b1; w_adr = 3'd6; w = 16'h6666;
    tick();
    rsv_en = 1'b0; we = 1'b0; r_adr = 3'd6;
    #1;
    chk("rsvwr_pend", 32'(pend_r), 32'h1);
    chk("rsvwr_data", 32'(r_bin), 32'h6666);

    // register 0 behaviour with and without hardwired zero
    we = 1'b1; w_adr = 3'd0; w = 16'hFFFF; r_adr = 3'd0;
    #1;
    chk("z_w_ack", 32'(z_w_ack), 32'h0);
    chk("z_r_bin", 32'(z_r_bin), 32'h0);
    chk("nz_w_ack", 32'(w_ack), 32'h1);
    chk("nz_r_byp", 32'(r_bin), 32'hFFFF);
    tick();
    we = 1'b0; rsv_en = 1'b1; rsv_adr = 3'd0;
    tick();
    rsv_en = 1'b0;
    #1;
    chk("z_pend0", 32'(z_pend_r), 32'h0);
    chk("z_r0_after", 32'(z_r_bin), 32'h0);
    chk("nz_pend0", 32'(pend_r), 32'h1);
    chk("nz_r0_after", 32'(r_bin), 32'hFFFF);

    // bulk clear: fill, reserve r1, then sweep
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; w_adr = 3'(i); w = 16'h00A0 + 16'(i);
      tick();
    end
    we = 1'b0;
    rsv_en = 1'b1; rsv_adr = 3'd1;
    tick();
    rsv_en = 1'b0; r_adr = 3'd1;
    #1;
    chk("pre_clr_pend1", 32'(pend_r), 32'h1);
    chk("pre_clr_r1", 32'(r_bin), 32'h00A1);
    clr_req = 1'b1;
    #1;
    chk("clr_busy_lag", 32'(clr_busy), 32'h0);
    tick();
    clr_req = 1'b0;
    #1;
    chk("clr_pend1_flushed", 32'(pend_r), 32'h0);
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!clr_busy) break;
      busy_cnt++;
      if (busy_cnt == 2) begin
        // sweep at cnt=1: r0 already zero, r1 and r4 still hold data
        we = 1'b1; w_adr = 3'd4; w = 16'h5555; r_adr = 3'd4; s_adr = 3'd1;
        #1;
        chk("mid_w_ack", 32'(w_ack), 32'h0);
        chk("mid_nobyp_r4", 32'(r_bin), 32'h00A4);
        chk("mid_r1_kept", 32'(s_bin), 32'h00A1);
        chk("mid_pend1", 32'(pend_s), 32'h0);
        r_adr = 3'd0;
        #1;
        chk("mid_r0_cleared", 32'(r_bin), 32'h0);
      end
      tick();
      we = 1'b0;
    end
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd8);
    for (int i = 0; i < 8; i++) begin
      r_adr = 3'(i);
      #1;
      chk($sformatf("post_clr_r%0d", i), 32'(r_bin), 32'h0);
    end

    // reset in the third CLEAR cycle aborts the sweep
    we = 1'b1; w_adr = 3'd2; w = 16'h2222;
    tick();
    w_adr = 3'd5; w = 16'h5A5A;
    tick();
    we = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    r_adr = 3'd5; s_adr = 3'd2;
    #1;
    chk("pre_abort_busy", 32'(clr_busy), 32'h1);
    chk("pre_abort_r5", 32'(r_bin), 32'h5A5A);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(clr_busy), 32'h0);
    chk("abort_r5", 32'(r_bin), 32'h0);
    chk("abort_r2", 32'(s_bin), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    we = 1'b1; w_adr = 3'd3; w = 16'h3333;
    #1;
    chk("post_abort_w_ack", 32'(w_ack), 32'h1);
    tick();
    we = 1'b0; r_adr = 3'd3;
    #1;
    chk("post_abort_r3", 32'(r_bin), 32'h3333);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
